// File: rtl/ublaze_axil_responder_pkg.sv
// ublaze_rsp_pkg: shared constants and types for the AXI4-Lite responder.
//   RESP_OKAY / RESP_SLVERR : AXI response encodings
//   DATA_W                  : register / bus data width
//   wstate_t / rstate_t     : write and read FSM state encodings
//   idx_in_range()          : register index decode helper
package ublaze_rsp_pkg;

   localparam int         DATA_W      = 32;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [2:0] {
      W_IDLE = 3'd0,
      W_ADDR = 3'd1,
      W_DATA = 3'd2,
      W_WAIT = 3'd3,
      W_RESP = 3'd4
   } wstate_t;

   typedef enum logic [1:0] {
      R_IDLE = 2'd0,
      R_WAIT = 2'd1,
      R_DATA = 2'd2
   } rstate_t;

   // True when a word index addresses an implemented register.
   function automatic logic idx_in_range(input logic [31:0] idx, input logic [31:0] nregs);
      return (idx < nregs);
   endfunction

endpackage

// File: rtl/ublaze_axil_responder_if.sv
// ublaze_axil_responder_if: AXI4-Lite channel bundle between the BFM master
// and the register-bank responder.
//   master modport : drives AW/W/AR payload+valid and B/R ready
//   slave modport  : drives AW/W/AR ready and B/R payload+valid
interface ublaze_axil_responder_if #(
   parameter int ADDR_W = 12
);
   import ublaze_rsp_pkg::*;

   logic [ADDR_W-1:0] s_awaddr;
   logic              s_awvalid;
   logic              s_awready;
   logic [DATA_W-1:0] s_wdata;
   logic [3:0]        s_wstrb;
   logic              s_wvalid;
   logic              s_wready;
   logic [1:0]        s_bresp;
   logic              s_bvalid;
   logic              s_bready;
   logic [ADDR_W-1:0] s_araddr;
   logic              s_arvalid;
   logic              s_arready;
   logic [DATA_W-1:0] s_rdata;
   logic [1:0]        s_rresp;
   logic              s_rvalid;
   logic              s_rready;

   modport master (
      output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
             s_araddr, s_arvalid, s_rready,
      input  s_awready, s_wready, s_bresp, s_bvalid, s_arready,
             s_rdata, s_rresp, s_rvalid
   );

   modport slave (
      input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
             s_araddr, s_arvalid, s_rready,
      output s_awready, s_wready, s_bresp, s_bvalid, s_arready,
             s_rdata, s_rresp, s_rvalid
   );

endinterface

// File: rtl/ublaze_axil_responder_regfile.sv
// ublaze_rsp_regfile: NREGS x 32-bit storage for the responder.
//   clk, rst_n         : clock, async active-low reset (clears all registers)
//   we, wr_idx         : write enable and word index (index already range-checked)
//   wr_data, wr_strb   : write data and byte strobes
//   rd_idx, rd_data    : combinational read port (returns 0 for unimplemented index)
//   reg_q              : flat register contents, reg k at [32k+31:32k]
//   wr_pulse           : one-cycle strobe per register, registered with the write
module ublaze_rsp_regfile
   import ublaze_rsp_pkg::*;
#(
   parameter int NREGS = 16,
   parameter int IDX_W = 10
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    we,
   input  logic [IDX_W-1:0]        wr_idx,
   input  logic [DATA_W-1:0]       wr_data,
   input  logic [3:0]              wr_strb,
   input  logic [IDX_W-1:0]        rd_idx,
   output logic [DATA_W-1:0]       rd_data,
   output logic [NREGS*DATA_W-1:0] reg_q,
   output logic [NREGS-1:0]        wr_pulse
);

   logic [NREGS-1:0][DATA_W-1:0] regs_r;
   logic [NREGS-1:0]             wr_pulse_r;

   // Byte-strobed register update and per-register write strobe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs_r     <= '0;
         wr_pulse_r <= '0;
      end else begin
         wr_pulse_r <= '0;
         for (int k = 0; k < NREGS; k++) begin
            if (we && (wr_idx == IDX_W'(k))) begin
               // strobe fires even with wstrb=0 so software can use it as a doorbell
               wr_pulse_r[k] <= 1'b1;
               for (int b = 0; b < 4; b++) begin
                  if (wr_strb[b]) begin
                     regs_r[k][8*b +: 8] <= wr_data[8*b +: 8];
                  end
               end
            end
         end
      end
   end

   // Read mux; an index that matches no register yields zero.
   always_comb begin
      rd_data = 32'h0000_0000;
      for (int k = 0; k < NREGS; k++) begin
         rd_data = rd_data | ((rd_idx == IDX_W'(k)) ? regs_r[k] : 32'h0000_0000);
      end
   end

   assign reg_q    = regs_r;
   assign wr_pulse = wr_pulse_r;

endmodule

// File: rtl/ublaze_axil_responder.sv
// ublaze_axil_responder: AXI4-Lite slave register bank for the MicroBlaze BFM.
//   clk, rst_n : clock, async active-low reset (abandons any open transaction)
//   bus        : AXI4-Lite slave port (ublaze_axil_responder_if.slave)
//   reg_q      : flat register contents, reg k at [32k+31:32k]
//   wr_pulse   : one-cycle strobe when reg k is written
// Optional feature macro UBLAZE_RSP_WAIT_EN: inserts WAIT_CYC wait states before
// each B and R response (commit and capture timing unchanged).
module ublaze_axil_responder
   import ublaze_rsp_pkg::*;
#(
   parameter int ADDR_W   = 12,
   parameter int NREGS    = 16,
   parameter int WAIT_CYC = 3
) (
   input  logic                     clk,
   input  logic                     rst_n,
   ublaze_axil_responder_if.slave   bus,
   output logic [NREGS*DATA_W-1:0]  reg_q,
   output logic [NREGS-1:0]         wr_pulse
);

   localparam int IDX_W = ADDR_W - 2;
   localparam int CNT_W = (WAIT_CYC > 1) ? $clog2(WAIT_CYC + 1) : 1;
`ifdef UBLAZE_RSP_WAIT_EN
   localparam bit WAIT_EN = (WAIT_CYC != 0);
`else
   localparam bit WAIT_EN = 1'b0;
`endif
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'((WAIT_CYC > 0) ? (WAIT_CYC - 1) : 0);
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   // state entered on a commit / capture edge
   localparam wstate_t W_AFTER = WAIT_EN ? W_WAIT : W_RESP;
   localparam rstate_t R_AFTER = WAIT_EN ? R_WAIT : R_DATA;

   wstate_t           wr_st_r, wr_nxt_s;
   logic [IDX_W-1:0]  aw_idx_r;
   logic [DATA_W-1:0] w_data_r;
   logic [3:0]        w_strb_r;
   logic [1:0]        bresp_r;
   logic [CNT_W-1:0]  wcnt_r;
   logic              aw_hs_s, w_hs_s, commit_s, cm_ok_s, we_s;
   logic [IDX_W-1:0]  cm_idx_s;
   logic [DATA_W-1:0] cm_data_s;
   logic [3:0]        cm_strb_s;

   rstate_t           rd_st_r, rd_nxt_s;
   logic [DATA_W-1:0] rdata_r, rd_data_s;
   logic [1:0]        rresp_r;
   logic [CNT_W-1:0]  rcnt_r;
   logic              ar_hs_s, ar_ok_s;
   logic [IDX_W-1:0]  ar_idx_s;

   // Ready/valid are pure decodes of registered state: no valid->ready path.
   assign bus.s_awready = (wr_st_r == W_IDLE) || (wr_st_r == W_DATA);
   assign bus.s_wready  = (wr_st_r == W_IDLE) || (wr_st_r == W_ADDR);
   assign bus.s_bvalid  = (wr_st_r == W_RESP);
   assign bus.s_bresp   = bresp_r;
   assign bus.s_arready = (rd_st_r == R_IDLE);
   assign bus.s_rvalid  = (rd_st_r == R_DATA);
   assign bus.s_rdata   = rdata_r;
   assign bus.s_rresp   = rresp_r;

   assign aw_hs_s  = bus.s_awvalid && bus.s_awready;
   assign w_hs_s   = bus.s_wvalid && bus.s_wready;
   assign ar_hs_s  = bus.s_arvalid && bus.s_arready;
   assign ar_idx_s = bus.s_araddr[ADDR_W-1:2];
   assign cm_ok_s  = idx_in_range(32'(cm_idx_s), 32'(NREGS));
   assign ar_ok_s  = idx_in_range(32'(ar_idx_s), 32'(NREGS));
   assign we_s     = commit_s && cm_ok_s;

   // Write FSM next state; selects commit operands from the live bus or held copies.
   always_comb begin
      wr_nxt_s  = wr_st_r;
      commit_s  = 1'b0;
      cm_idx_s  = aw_idx_r;
      cm_data_s = w_data_r;
      cm_strb_s = w_strb_r;
      case (wr_st_r)
         W_IDLE: begin
            if (aw_hs_s && w_hs_s) begin
               commit_s  = 1'b1;
               cm_idx_s  = bus.s_awaddr[ADDR_W-1:2];
               cm_data_s = bus.s_wdata;
               cm_strb_s = bus.s_wstrb;
               wr_nxt_s  = W_AFTER;
            end else if (aw_hs_s) begin
               wr_nxt_s = W_ADDR;
            end else if (w_hs_s) begin
               wr_nxt_s = W_DATA;
            end else begin
               wr_nxt_s = W_IDLE;
            end
         end
         W_ADDR: begin
            if (w_hs_s) begin
               commit_s  = 1'b1;
               cm_data_s = bus.s_wdata;
               cm_strb_s = bus.s_wstrb;
               wr_nxt_s  = W_AFTER;
            end else begin
               wr_nxt_s = W_ADDR;
            end
         end
         W_DATA: begin
            if (aw_hs_s) begin
               commit_s = 1'b1;
               cm_idx_s = bus.s_awaddr[ADDR_W-1:2];
               wr_nxt_s = W_AFTER;
            end else begin
               wr_nxt_s = W_DATA;
            end
         end
         W_WAIT: begin
            if (wcnt_r == CNT_ZERO) begin
               wr_nxt_s = W_RESP;
            end else begin
               wr_nxt_s = W_WAIT;
            end
         end
         W_RESP: begin
            if (bus.s_bready) begin
               wr_nxt_s = W_IDLE;
            end else begin
               wr_nxt_s = W_RESP;
            end
         end
         default: wr_nxt_s = W_IDLE;
      endcase
   end

   // Write FSM state, held AW/W halves, response code and wait counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_st_r  <= W_IDLE;
         aw_idx_r <= {IDX_W{1'b0}};
         w_data_r <= 32'h0000_0000;
         w_strb_r <= 4'h0;
         bresp_r  <= RESP_OKAY;
         wcnt_r   <= CNT_ZERO;
      end else begin
         wr_st_r <= wr_nxt_s;
         if (aw_hs_s) begin
            aw_idx_r <= bus.s_awaddr[ADDR_W-1:2];
         end
         if (w_hs_s) begin
            w_data_r <= bus.s_wdata;
            w_strb_r <= bus.s_wstrb;
         end
         if (commit_s) begin
            bresp_r <= cm_ok_s ? RESP_OKAY : RESP_SLVERR;
            wcnt_r  <= CNT_LOAD;
         end else if (wr_st_r == W_WAIT) begin
            wcnt_r <= wcnt_r - CNT_ONE;
         end
      end
   end

   // Read FSM next state.
   always_comb begin
      rd_nxt_s = rd_st_r;
      case (rd_st_r)
         R_IDLE: begin
            if (ar_hs_s) begin
               rd_nxt_s = R_AFTER;
            end else begin
               rd_nxt_s = R_IDLE;
            end
         end
         R_WAIT: begin
            if (rcnt_r == CNT_ZERO) begin
               rd_nxt_s = R_DATA;
            end else begin
               rd_nxt_s = R_WAIT;
            end
         end
         R_DATA: begin
            if (bus.s_rready) begin
               rd_nxt_s = R_IDLE;
            end else begin
               rd_nxt_s = R_DATA;
            end
         end
         default: rd_nxt_s = R_IDLE;
      endcase
   end

   // Read FSM state and capture; a capture coincident with a commit sees the old value.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_st_r <= R_IDLE;
         rdata_r <= 32'h0000_0000;
         rresp_r <= RESP_OKAY;
         rcnt_r  <= CNT_ZERO;
      end else begin
         rd_st_r <= rd_nxt_s;
         if (ar_hs_s) begin
            rdata_r <= ar_ok_s ? rd_data_s : 32'h0000_0000;
            rresp_r <= ar_ok_s ? RESP_OKAY : RESP_SLVERR;
            rcnt_r  <= CNT_LOAD;
         end else if (rd_st_r == R_WAIT) begin
            rcnt_r <= rcnt_r - CNT_ONE;
         end
      end
   end

   ublaze_rsp_regfile #(
      .NREGS (NREGS),
      .IDX_W (IDX_W)
   ) u_regfile (
      .clk      (clk),
      .rst_n    (rst_n),
      .we       (we_s),
      .wr_idx   (cm_idx_s),
      .wr_data  (cm_data_s),
      .wr_strb  (cm_strb_s),
      .rd_idx   (ar_idx_s),
      .rd_data  (rd_data_s),
      .reg_q    (reg_q),
      .wr_pulse (wr_pulse)
   );

endmodule

// File: tb/tb_ublaze_axil_responder.sv
// Self-checking bench for ublaze_axil_responder: directed steps, a register
// model and response scoreboards (expected B/R responses queued at issue time).
module tb_ublaze_axil_responder;
   import ublaze_rsp_pkg::*;

   localparam int ADDR_W   = 12;
   localparam int NREGS    = 16;
   localparam int WAIT_CYC = 3;
`ifdef UBLAZE_RSP_WAIT_EN
   localparam int EXP_WAIT = WAIT_CYC;
`else
   localparam int EXP_WAIT = 0;
`endif

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [NREGS*32-1:0] reg_q;
   logic [NREGS-1:0]    wr_pulse;

   int checks = 0;
   int failures = 0;
   logic [31:0] mdl [NREGS];
   logic [17:0] exp_b_q [$];   // {bresp, expected wr_pulse}
   logic [33:0] exp_r_q [$];   // {rresp, rdata}

   ublaze_axil_responder_if #(.ADDR_W(ADDR_W)) bus ();

   ublaze_axil_responder #(
      .ADDR_W   (ADDR_W),
      .NREGS    (NREGS),
      .WAIT_CYC (WAIT_CYC)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .bus      (bus),
      .reg_q    (reg_q),
      .wr_pulse (wr_pulse)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [NREGS*32-1:0] mdl_flat();
      logic [NREGS*32-1:0] f;
      f = '0;
      for (int k = 0; k < NREGS; k++) f[32*k +: 32] = mdl[k];
      return f;
   endfunction

   task automatic exp_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s);
      int idx;
      logic [15:0] pulse;
      idx = int'(a[11:2]);
      pulse = 16'h0000;
      if (idx < NREGS) begin
         pulse[idx] = 1'b1;
         for (int b = 0; b < 4; b++) if (s[b]) mdl[idx][8*b +: 8] = d[8*b +: 8];
         exp_b_q.push_back({RESP_OKAY, pulse});
      end else begin
         exp_b_q.push_back({RESP_SLVERR, pulse});
      end
   endtask

   task automatic exp_read(input logic [11:0] a);
      int idx;
      idx = int'(a[11:2]);
      if (idx < NREGS) exp_r_q.push_back({RESP_OKAY, mdl[idx]});
      else             exp_r_q.push_back({RESP_SLVERR, 32'h0000_0000});
   endtask

   // lead = cycles the W beat precedes the AW beat (0 = same cycle)
   task automatic wr_drive(input logic [11:0] a, input logic [31:0] d, input logic [3:0] s, input int lead);
      @(negedge clk);
      bus.s_wdata = d; bus.s_wstrb = s; bus.s_wvalid = 1'b1;
      if (lead == 0) begin bus.s_awaddr = a; bus.s_awvalid = 1'b1; end
      @(posedge clk); #1;
      bus.s_wvalid = 1'b0; bus.s_awvalid = 1'b0;
      if (lead > 0) begin
         repeat (lead - 1) @(negedge clk);
         @(negedge clk);
         bus.s_awaddr = a; bus.s_awvalid = 1'b1;
         @(posedge clk); #1;
         bus.s_awvalid = 1'b0;
      end
   endtask

   task automatic wr_resp(input int hold, input bit chk_lat);
      int n;
      logic [17:0] e;
      n = 0;
      @(negedge clk);
      while (bus.s_bvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("b_timeout", 512'(n < 50), 512'(1));
      if (chk_lat) chk("b_latency", 512'(n), 512'(EXP_WAIT));
      e = exp_b_q.pop_front();
      chk("bresp", 512'(bus.s_bresp), 512'(e[17:16]));
`ifndef UBLAZE_RSP_WAIT_EN
      chk("wr_pulse", 512'(wr_pulse), 512'(e[15:0]));
`endif
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("b_hold_valid", 512'(bus.s_bvalid), 512'(1));
         chk("b_hold_resp", 512'(bus.s_bresp), 512'(e[17:16]));
      end
      bus.s_bready = 1'b1;
      @(posedge clk); #1;
      bus.s_bready = 1'b0;
      @(negedge clk);
      chk("b_drop", 512'(bus.s_bvalid), 512'(0));
      chk("wr_pulse_once", 512'(wr_pulse), 512'(0));
      chk("aw_ready_back", 512'({bus.s_awready, bus.s_wready}), 512'(2'b11));
      chk("reg_q", 512'(reg_q), 512'(mdl_flat()));
   endtask

   task automatic rd_drive(input logic [11:0] a);
      @(negedge clk);
      bus.s_araddr = a; bus.s_arvalid = 1'b1;
      @(posedge clk); #1;
      bus.s_arvalid = 1'b0;
   endtask

   task automatic rd_resp(input int hold, input bit chk_lat);
      int n;
      logic [33:0] e;
      n = 0;
      @(negedge clk);
      while (bus.s_rvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("r_timeout", 512'(n < 50), 512'(1));
      if (chk_lat) chk("r_latency", 512'(n), 512'(EXP_WAIT));
      e = exp_r_q.pop_front();
      chk("rdata", 512'(bus.s_rdata), 512'(e[31:0]));
      chk("rresp", 512'(bus.s_rresp), 512'(e[33:32]));
      for (int i = 0; i < hold; i++) begin
         @(negedge clk);
         chk("r_hold_valid", 512'(bus.s_rvalid), 512'(1));
         chk("r_hold_data", 512'(bus.s_rdata), 512'(e[31:0]));
      end
      bus.s_rready = 1'b1;
      @(posedge clk); #1;
      bus.s_rready = 1'b0;
      @(negedge clk);
      chk("r_drop", 512'(bus.s_rvalid), 512'(0));
   endtask

   initial begin
      int n;
      int rv_cnt;
      bus.s_awaddr = 12'h000; bus.s_awvalid = 1'b0;
      bus.s_wdata = 32'h0; bus.s_wstrb = 4'h0; bus.s_wvalid = 1'b0;
      bus.s_bready = 1'b0;
      bus.s_araddr = 12'h000; bus.s_arvalid = 1'b0; bus.s_rready = 1'b0;
      for (int k = 0; k < NREGS; k++) mdl[k] = 32'h0;

      // reset state
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_ready", 512'({bus.s_awready, bus.s_wready, bus.s_arready}), 512'(3'b111));
      chk("rst_valid", 512'({bus.s_bvalid, bus.s_rvalid}), 512'(2'b00));
      chk("rst_resp", 512'({bus.s_bresp, bus.s_rresp}), 512'(4'h0));
      chk("rst_rdata", 512'(bus.s_rdata), 512'(0));
      chk("rst_reg_q", 512'(reg_q), 512'(0));
      chk("rst_wr_pulse", 512'(wr_pulse), 512'(0));

      // read of register 0 after reset
      exp_read(12'h000); rd_drive(12'h000); rd_resp(0, 1'b1);

      // full-word write, AW and W together
      exp_write(12'h004, 32'hA5A5_1234, 4'hF); wr_drive(12'h004, 32'hA5A5_1234, 4'hF, 0); wr_resp(0, 1'b1);
      chk("reg1_value", 512'(reg_q[63:32]), 512'(32'hA5A5_1234));
      exp_read(12'h004); rd_drive(12'h004); rd_resp(0, 1'b1);

      // partial strobes, W two cycles ahead of AW
      exp_write(12'h008, 32'h1122_3344, 4'hF); wr_drive(12'h008, 32'h1122_3344, 4'hF, 0); wr_resp(0, 1'b1);
      exp_write(12'h008, 32'hFFFF_FFFF, 4'b0101); wr_drive(12'h008, 32'hFFFF_FFFF, 4'b0101, 2); wr_resp(0, 1'b1);
      chk("reg2_merge", 512'(reg_q[95:64]), 512'(32'h11FF_33FF));
      exp_read(12'h008); rd_drive(12'h008); rd_resp(0, 1'b1);

      // wstrb=0: OKAY and a pulse, no data change
      exp_write(12'h004, 32'hFFFF_FFFF, 4'h0); wr_drive(12'h004, 32'hFFFF_FFFF, 4'h0, 0); wr_resp(0, 1'b1);

      // last register, low address bits ignored
      exp_write(12'h03F, 32'h0F0F_0F0F, 4'hF); wr_drive(12'h03F, 32'h0F0F_0F0F, 4'hF, 0); wr_resp(0, 1'b1);
      chk("reg15_value", 512'(reg_q[511:480]), 512'(32'h0F0F_0F0F));

      // out of range: SLVERR, no pulse, no change
      exp_write(12'h040, 32'hDEAD_BEEF, 4'hF); wr_drive(12'h040, 32'hDEAD_BEEF, 4'hF, 0); wr_resp(0, 1'b1);
      exp_read(12'h040); rd_drive(12'h040); rd_resp(0, 1'b1);

      // back-pressure on B and R for 5 cycles
      exp_write(12'h010, 32'h5A5A_C3C3, 4'hF); wr_drive(12'h010, 32'h5A5A_C3C3, 4'hF, 1); wr_resp(5, 1'b0);
      exp_read(12'h010); rd_drive(12'h010); rd_resp(5, 1'b1);

      // read captured on the same edge as a write to that register returns the old value
      exp_read(12'h010);
      exp_write(12'h010, 32'h2222_5555, 4'hF);
      @(negedge clk);
      bus.s_awaddr = 12'h010; bus.s_awvalid = 1'b1;
      bus.s_wdata = 32'h2222_5555; bus.s_wstrb = 4'hF; bus.s_wvalid = 1'b1;
      bus.s_araddr = 12'h010; bus.s_arvalid = 1'b1;
      @(posedge clk); #1;
      bus.s_awvalid = 1'b0; bus.s_wvalid = 1'b0; bus.s_arvalid = 1'b0;
      wr_resp(0, 1'b1);
      rd_resp(0, 1'b0);
      exp_read(12'h010); rd_drive(12'h010); rd_resp(0, 1'b1);

`ifndef UBLAZE_RSP_WAIT_EN
      // back-to-back reads with rready tied high: one beat every 2 cycles
      rv_cnt = 0;
      @(negedge clk);
      bus.s_araddr = 12'h004; bus.s_arvalid = 1'b1; bus.s_rready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (bus.s_rvalid === 1'b1) begin
            rv_cnt++;
            chk("b2b_rdata", 512'(bus.s_rdata), 512'(mdl[1]));
         end
      end
      bus.s_arvalid = 1'b0;
      @(negedge clk);
      bus.s_rready = 1'b0;
      chk("b2b_beats", 512'(rv_cnt), 512'(3));
      @(negedge clk);
`endif

      // reset while a write response is pending
      exp_write(12'h00C, 32'hCAFE_F00D, 4'hF); wr_drive(12'h00C, 32'hCAFE_F00D, 4'hF, 0);
      n = 0;
      @(negedge clk);
      while (bus.s_bvalid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
      chk("pre_rst_bvalid", 512'(bus.s_bvalid), 512'(1));
      rst_n = 1'b0;
      #1;
      chk("mid_rst_bvalid", 512'(bus.s_bvalid), 512'(0));
      chk("mid_rst_regs", 512'(reg_q), 512'(0));
      exp_b_q.delete();
      for (int k = 0; k < NREGS; k++) mdl[k] = 32'h0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      chk("post_rst_bvalid", 512'(bus.s_bvalid), 512'(0));
      chk("post_rst_ready", 512'({bus.s_awready, bus.s_wready, bus.s_arready}), 512'(3'b111));
      exp_read(12'h004); rd_drive(12'h004); rd_resp(0, 1'b1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends.
   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

endmodule
